serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK. NCH = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-006 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract; sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in for add mode, sampled with start; ignored when sub=1.
REQ-008 The block SHALL have ports a and b, inputs, WIDTH bits each: operands, sampled with start.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse when a result becomes valid.
REQ-011 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-012 The block SHALL have port cout, output, 1 bit: unsigned carry-out; in subtract mode it is 1 when there is no borrow (a >= b unsigned).
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at an edge: the block SHALL capture a; capture b if sub=0, else ~b; set the carry register to cin if sub=0, else 1; clear the chunk counter; go to RUN.
REQ-016 IDLE with start=0: the block SHALL stay in IDLE.
REQ-017 In each RUN cycle the block SHALL add slice k (bits k*CHUNK+CHUNK-1 .. k*CHUNK, LSB slice first) of both captured operands plus the carry register as a CHUNK-bit ripple addition, store the slice result, update the carry register, and increment k.
REQ-018 After exactly NCH RUN cycles the block SHALL go to DONE, loading sum, cout (the final carry) and ovf (carry into the MSB XOR carry out of the MSB).
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency: with start sampled at the edge ending cycle C0, busy SHALL be 1 in cycles C1..C(NCH), and done SHALL be 1 only in cycle C(NCH+1).
REQ-021 sum, cout and ovf SHALL change only on entry to DONE and SHALL then hold until the next DONE or reset; intermediate slices SHALL NOT be visible on sum.
REQ-022 busy SHALL be 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in RUN and DONE. Operands and mode SHALL NOT be re-sampled, and a/b changes during RUN SHALL NOT affect the result.
REQ-024 Back-to-back operation: start=1 in the DONE cycle SHALL be ignored; the next operation SHALL be accepted in IDLE, so the minimum issue interval is NCH+2 cycles.
REQ-025 Results SHALL be arithmetic modulo 2^WIDTH, and no other status SHALL be generated.
REQ-026 CHUNK=WIDTH SHALL give one RUN cycle. CHUNK=1 SHALL give WIDTH RUN cycles (bit-serial).

Reset
REQ-027 While rst=1 at an edge the block SHALL go to IDLE, with busy=0, done=0, sum=0, cout=0, ovf=0, and the counter and carry cleared.
REQ-028 rst SHALL take priority over start and over all state transitions.
REQ-029 Reset during RUN or DONE SHALL abort the operation: no done pulse, and the partial result is discarded.

Verification
REQ-030 WIDTH=16, CHUNK=4: add a=0x1234, b=0x0FCD, cin=0 -> busy for 4 cycles, done in C5, sum=0x2201, cout=0, ovf=0.
REQ-031 Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Add a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
REQ-032 Subtract a=0x0005, b=0x0007, with cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Subtract a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 Start a=0x0001, b=0x0001, then pulse start with new operands in C2 and in the DONE cycle -> both pulses ignored, single result sum=0x0002, and previous sum held until C5.
REQ-034 Start an operation, then assert rst in C2 -> from C3: busy=0, sum=0, no done pulse. A new start after reset completes normally.
REQ-035 Re-run REQ-030 with CHUNK=16 (done in C2) and CHUNK=1 (done in C17) -> identical sum, cout and ovf.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, LSB slice first, and publishes sum/cout/ovf only when it finishes.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic [CHUNK-1:0] w_aSlice;
  logic [CHUNK-1:0] w_bSlice;
  logic [CHUNK:0]   w_sliceWide;
  logic [CHUNK-1:0] w_sliceSum;
  logic             w_sliceCout;
  logic             w_carryIntoMsb;
  logic             w_lastSlice;
  logic [WIDTH-1:0] w_accNext;

  // Operands shift right each RUN cycle so the current slice always sits in the
  // low CHUNK bits; slice results enter the accumulator from the top, so after
  // NCH cycles the first slice has reached bit 0. The carry into the slice MSB
  // is recovered from the sum bit and is only meaningful for the final slice.
  always_comb begin
    w_aSlice       = r_a[CHUNK-1:0];
    w_bSlice       = r_b[CHUNK-1:0];
    w_sliceWide    = {1'b0, w_aSlice} + {1'b0, w_bSlice} + {{CHUNK{1'b0}}, r_carry};
    w_sliceSum     = w_sliceWide[CHUNK-1:0];
    w_sliceCout    = w_sliceWide[CHUNK];
    w_carryIntoMsb = w_sliceSum[CHUNK-1] ^ w_aSlice[CHUNK-1] ^ w_bSlice[CHUNK-1];
    w_accNext      = (r_acc >> CHUNK) | (WIDTH'(w_sliceSum) << (WIDTH - CHUNK));
    w_lastSlice    = (r_k == KW'(NCH - 1));
  end

  // Control FSM and datapath: capture in IDLE, one slice per RUN cycle, and a
  // one-cycle DONE that is the only place the visible result registers change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_acc   <= w_accNext;
          r_carry <= w_sliceCout;
          r_k     <= r_k + 1'b1;
          if (w_lastSlice) begin
            sum     <= w_accNext;
            cout    <= w_sliceCout;
            ovf     <= w_carryIntoMsb ^ w_sliceCout;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
